// File: rtl/on_board.sv
// Egg-timer top level: MM:SS countdown entered from SW, driven by KEY[2:1].
// KEY[0] is an asynchronous active-high reset. STATE exposes the FSM code.
// Optional macro ONBOARD_DONE_FLASH_EN makes LEDR blink in DONE instead of
// staying steadily lit.
module on_board #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic [2:0] KEY,
  input  logic [7:0] SW,
  output logic [3:0] STATE,
  output logic [9:0] LEDR,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  typedef enum logic [3:0] {
    StSetSec = 4'd0,
    StSetMin = 4'd1,
    StRun    = 4'd2,
    StPause  = 4'd3,
    StDone   = 4'd4
  } state_e;

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CLK_HZ - 1);

  logic rst;
  assign rst = KEY[0];

  state_e        state_q, state_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    min_q, min_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sw_q;
  logic [1:0]    sync1_q, sync2_q, sync3_q, pulse_q;

  logic       key_set, key_go, tick, time_one;
  logic [5:0] sec_load;
  logic [6:0] min_load;

  assign key_set  = pulse_q[0];
  assign key_go   = pulse_q[1];
  assign tick     = (presc_q == PreMax);
  assign time_one = (min_q == 7'd0) && (sec_q == 6'd1);
  assign sec_load = (SW > 8'd59) ? 6'd59 : SW[5:0];
  assign min_load = (SW > 8'd99) ? 7'd99 : SW[6:0];

  // Two-flop synchronizer, edge-detect flop, registered one-cycle pulse; SW mirror for LEDR.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pulse_q <= '0;
      sw_q    <= '0;
    end else begin
      sync1_q <= KEY[2:1];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pulse_q <= sync2_q & ~sync3_q;
      sw_q    <= SW;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= StSetSec;
    else     state_q <= state_d;
  end

  // Next-state logic; KEY[1] wins over KEY[2], and a key pulse swallows a coincident tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSetSec: if (key_set) state_d = StSetMin;
      StSetMin: begin
        if (key_set) state_d = (min_load == 7'd0 && sec_q == 6'd0) ? StDone : StRun;
      end
      StRun: begin
        if (key_set)               state_d = StSetSec;
        else if (key_go)           state_d = StPause;
        else if (tick && time_one) state_d = StDone;
      end
      StPause: begin
        if (key_set)     state_d = StSetSec;
        else if (key_go) state_d = StRun;
      end
      StDone:  if (key_set || key_go) state_d = StSetSec;
      default: state_d = StSetSec;
    endcase
  end

  // Time and prescaler next-state: loading, countdown, and clear on abort.
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    presc_d = presc_q;
    unique case (state_q)
      StSetSec: if (key_set) sec_d = sec_load;
      StSetMin: begin
        if (key_set) begin
          min_d   = min_load;
          presc_d = '0;
        end
      end
      StRun: begin
        if (key_set) begin
          sec_d   = '0;
          min_d   = '0;
          presc_d = '0;
        end else if (key_go) begin
          presc_d = presc_q;  // hold phase across pause
        end else if (tick) begin
          presc_d = '0;
          if (sec_q == 6'd0) begin
            sec_d = 6'd59;
            min_d = min_q - 7'd1;
          end else begin
            sec_d = sec_q - 6'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StPause: begin
        if (key_set) begin
          sec_d   = '0;
          min_d   = '0;
          presc_d = '0;
        end
      end
      StDone: begin
        if (key_set || key_go) begin
          sec_d   = '0;
          min_d   = '0;
          presc_d = '0;
        end
      end
      default: begin
        sec_d   = '0;
        min_d   = '0;
        presc_d = '0;
      end
    endcase
  end

  // Time and prescaler registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sec_q   <= '0;
      min_q   <= '0;
      presc_q <= '0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      presc_q <= presc_d;
    end
  end

`ifdef ONBOARD_DONE_FLASH_EN
  localparam int unsigned FlashHalf = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int unsigned FW = (FlashHalf > 1) ? $clog2(FlashHalf) : 1;
  localparam logic [FW-1:0] FlashMax = FW'(FlashHalf - 1);

  logic [FW-1:0] flash_cnt_q;
  logic          flash_on_q;
  logic          done_lit;

  // Blink phase counter; restarts lit every time DONE is entered.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else if (state_q != StDone) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else if (flash_cnt_q == FlashMax) begin
      flash_cnt_q <= '0;
      flash_on_q  <= ~flash_on_q;
    end else begin
      flash_cnt_q <= flash_cnt_q + FW'(1);
    end
  end
  assign done_lit = flash_on_q;
`else
  logic done_lit;
  assign done_lit = 1'b1;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Outputs decoded from registers only.
  always_comb begin
    STATE = state_q;
    LEDR  = '0;
    unique case (state_q)
      StSetSec, StSetMin: LEDR[7:0] = sw_q;
      StRun:              LEDR[8]   = 1'b1;
      StPause:            LEDR[9]   = 1'b1;
      StDone:             LEDR      = done_lit ? 10'h3FF : 10'h000;
      default:            LEDR      = '0;
    endcase
    HEX3 = seg7(4'(min_q / 7'd10));
    HEX2 = seg7(4'(min_q % 7'd10));
    HEX1 = seg7(4'(sec_q / 6'd10));
    HEX0 = seg7(4'(sec_q % 6'd10));
  end

endmodule

// File: tb/tb_on_board.sv
// Scoreboard bench for on_board: a total-seconds reference model predicts each
// visible change of STATE/HEX (with the cycle it should appear); a monitor pops
// and compares whenever the DUT display tuple changes.
module tb_on_board;
  localparam int unsigned HZ = 4;

  logic       CLK = 1'b0;
  logic [2:0] KEY;
  logic [7:0] SW;
  logic [3:0] STATE;
  logic [9:0] LEDR;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;

  always #5 CLK = ~CLK;

  on_board #(.CLK_HZ(HZ)) dut (
    .CLK  (CLK),
    .KEY  (KEY),
    .SW   (SW),
    .STATE(STATE),
    .LEDR (LEDR),
    .HEX3 (HEX3),
    .HEX2 (HEX2),
    .HEX1 (HEX1),
    .HEX0 (HEX0)
  );

  typedef struct {
    int         st;
    int         mm;
    int         ss;
    logic [9:0] ledr;
    int         stamp;  // -1: no cycle requirement
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [31:0] tuple_of(input int st, input int mm, input int ss);
    tuple_of = {4'(st), seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10)};
  endfunction

  // ---------------- reference model ----------------
  int         m_st = 0, m_mm = 0, m_ss = 0, m_ph = 0;
  int         l_st = 0, l_mm = 0, l_ss = 0;
  logic [4:0] h1 = '0, h2 = '0;
  logic [7:0] m_sw = '0;

  task automatic publish(input int stamp);
    exp_t e;
    if (m_st != l_st || m_mm != l_mm || m_ss != l_ss) begin
      e.st = m_st; e.mm = m_mm; e.ss = m_ss; e.stamp = stamp;
      case (m_st)
        0, 1:    e.ledr = (stamp < 0) ? 10'h000 : {2'b00, m_sw};
        2:       e.ledr = 10'h100;
        3:       e.ledr = 10'h200;
        default: e.ledr = 10'h3FF;
      endcase
      q.push_back(e);
      l_st = m_st; l_mm = m_mm; l_ss = m_ss;
    end
  endtask

  task automatic clear_time();
    m_st = 0; m_mm = 0; m_ss = 0;
  endtask

  initial begin : model
    int  t;
    bit  p1, p2;
    forever begin
      @(posedge CLK or posedge KEY[0]);
      if (KEY[0] === 1'b1) begin
        clear_time(); m_ph = 0; h1 = '0; h2 = '0; m_sw = '0;
        publish(-1);
      end else begin
        cyc++;
        h1 = {h1[3:0], KEY[1]};
        h2 = {h2[3:0], KEY[2]};
        m_sw = SW;
        // rising edge sampled three edges ago takes effect now
        p1 = h1[3] & ~h1[4];
        p2 = h2[3] & ~h2[4];
        case (m_st)
          0: if (p1) begin m_ss = (SW > 59) ? 59 : int'(SW); m_st = 1; end
          1: if (p1) begin
            m_mm = (SW > 99) ? 99 : int'(SW);
            if (m_mm * 60 + m_ss == 0) m_st = 4;
            else begin m_st = 2; m_ph = 0; end
          end
          2: begin
            if (p1) clear_time();
            else if (p2) m_st = 3;
            else if (m_ph == HZ - 1) begin
              m_ph = 0;
              t = m_mm * 60 + m_ss - 1;
              m_mm = t / 60; m_ss = t % 60;
              if (t == 0) m_st = 4;
            end else m_ph++;
          end
          3: if (p1) clear_time(); else if (p2) m_st = 2;
          default: if (p1 || p2) clear_time();
        endcase
        publish(cyc);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [31:0] last, cur, want;
    exp_t e;
    last = tuple_of(0, 0, 0);
    forever begin
      @(negedge CLK);
      cur = {STATE, HEX3, HEX2, HEX1, HEX0};
      if (cur !== last) begin
        last = cur;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got tuple=%h ledr=%h at cyc=%0d, required no change",
                   cur, LEDR, cyc);
        end else begin
          e = q.pop_front();
          want = tuple_of(e.st, e.mm, e.ss);
          if (cur !== want || LEDR !== e.ledr || (e.stamp >= 0 && e.stamp != cyc)) begin
            errors++;
            $display("FAIL display_event: got state=%0d tuple=%h ledr=%h cyc=%0d, required state=%0d %02d:%02d tuple=%h ledr=%h cyc=%0d",
                     STATE, cur, LEDR, cyc, e.st, e.mm, e.ss, want, e.ledr, e.stamp);
          end
        end
      end else if (q.size() > 0 && q[0].stamp >= 0 && cyc > q[0].stamp) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missed_event: got tuple=%h at cyc=%0d, required state=%0d %02d:%02d at cyc=%0d",
                 cur, cyc, e.st, e.mm, e.ss, e.stamp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int k, input int hold);
    @(negedge CLK);
    KEY[k] = 1'b1;
    repeat (hold) @(negedge CLK);
    KEY[k] = 1'b0;
    wait_cyc(4);
  endtask

  task automatic press_both();
    @(negedge CLK);
    KEY[2:1] = 2'b11;
    wait_cyc(2);
    KEY[2:1] = 2'b00;
    wait_cyc(4);
  endtask

  task automatic set_sw(input logic [7:0] v);
    @(negedge CLK);
    SW = v;
    wait_cyc(3);
  endtask

  task automatic load(input logic [7:0] s, input logic [7:0] m);
    set_sw(s);
    press(1, 2);
    set_sw(m);
    press(1, 2);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    #2 KEY[0] = 1'b1;
    #1;
    checks++;
    if (STATE !== 4'd0 || LEDR !== 10'h000 || HEX3 !== 7'h40 || HEX2 !== 7'h40 ||
        HEX1 !== 7'h40 || HEX0 !== 7'h40) begin
      errors++;
      $display("FAIL async_reset: got state=%0d ledr=%h hex=%h_%h_%h_%h, required 0 000 40_40_40_40",
               STATE, LEDR, HEX3, HEX2, HEX1, HEX0);
    end
    repeat (n) @(negedge CLK);
    KEY[0] = 1'b0;
  endtask

  initial begin : stim
    int r;
    KEY = 3'b001;
    SW  = 8'h00;
    wait_cyc(5);
    KEY[0] = 1'b0;
    wait_cyc(3);

    load(8'hA3, 8'hD6);           // saturates to 99:59, RUN
    wait_cyc(21);
    press(2, 3);                  // pause
    wait_cyc(50);
    press(2, 1);                  // resume
    wait_cyc(9);
    do_reset(10);                 // abort mid-run

    load(8'd0, 8'd1);             // 01:00
    wait_cyc(10);
    press(1, 2);                  // abort to SET_SEC
    load(8'd1, 8'd0);             // 00:01 -> DONE
    wait_cyc(10);
    press(2, 2);                  // DONE -> SET_SEC
    load(8'd0, 8'd0);             // straight to DONE
    press(2, 1);

    set_sw(8'd7);
    press(1, 100);                // long hold: one step only
    set_sw(8'd2);
    press(1, 1);                  // 02:07 RUN
    wait_cyc(6);
    press_both();                 // KEY[1] priority -> SET_SEC

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 3) begin
        set_sw(8'($urandom_range(0, 255)));
        press(1, $urandom_range(1, 6));
      end else if (r <= 5) begin
        press(2, $urandom_range(1, 6));
      end else if (r == 6) begin
        press_both();
      end else if (r == 7) begin
        do_reset($urandom_range(1, 5));
      end else begin
        wait_cyc($urandom_range(1, 40));
      end
    end

    wait_cyc(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
